// File: rtl/squeeze_pkg.sv
// ------------------------------------------------------------------
// squeeze_pkg: descriptor layout, FSM states and expected-count math
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package squeeze_pkg;

  localparam int DESC_W  = 37;
  localparam int CNT_W   = 24;

  localparam int LIM_LSB = 0;
  localparam int LIM_W   = 9;
  localparam int KER_LSB = 9;
  localparam int KER_W   = 10;
  localparam int DEP_LSB = 19;
  localparam int DEP_W   = 9;
  localparam int DIM_LSB = 28;
  localparam int DIM_W   = 7;
  localparam int EXP_BIT = 35;
  localparam int AVG_BIT = 36;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_CLR   = 3'd2,
    ST_START = 3'd3,
    ST_RUN   = 3'd4,
    ST_NEXT  = 3'd5
  } state_e;

  // (D+1)^2*(K+1) peaks at exactly 2^24, so one extra bit is kept and clamped.
  function automatic logic [CNT_W-1:0] calc_expected(
    input logic             avg,
    input logic [DIM_W-1:0] dim,
    input logic [KER_W-1:0] ker
  );
    logic [7:0]  dp1;
    logic [10:0] kp1;
    logic [15:0] sq;
    logic [24:0] prod;
    dp1  = {1'b0, dim} + 8'd1;
    kp1  = {1'b0, ker} + 11'd1;
    sq   = 16'(dp1) * 16'(dp1);
    prod = 25'(sq) * 25'(kp1);
    if (avg)
      calc_expected = CNT_W'(kp1);
    else if (prod[24])
      calc_expected = '1;
    else
      calc_expected = prod[23:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/squ_desc_ram.sv
// ------------------------------------------------------------------
// squ_desc_ram: simple dual-port descriptor RAM, registered write-first read
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module squ_desc_ram #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3,
  parameter int DATA_W = 37
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_addr] <= wr_data;
    if (wr_en && (wr_addr == rd_addr))
      rd_data <= wr_data;
    else
      rd_data <= mem[rd_addr];
  end

endmodule

`default_nettype wire

// File: rtl/squeeze_layer_sequencer.sv
// ------------------------------------------------------------------
// squeeze_layer_sequencer: steps max_2_squeeze_top through a layer table
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module squeeze_layer_sequencer
  import squeeze_pkg::*;
#(
  parameter int NUM_LAYERS = 8,
  parameter int LAYER_W    = 3
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               cfg_wr_en_i,
  input  logic [LAYER_W-1:0] cfg_wr_addr_i,
  input  logic [DESC_W-1:0]  cfg_wr_data_i,
  input  logic [LAYER_W-1:0] last_layer_i,
  input  logic               run_i,
  input  logic               abort_i,
  input  logic               out_beat_i,
  output logic               start_o,
  output logic               fifo_squ_bash_clr_o,
  output logic               exp_1x1_en_o,
  output logic               avg_en_o,
  output logic [LIM_W-1:0]   tot_squ_addr_limit_o,
  output logic [KER_W-1:0]   no_of_squ_kernals_o,
  output logic [DEP_W-1:0]   squ_3x3_ker_depth_o,
  output logic [DIM_W-1:0]   squ_layer_dimension_o,
  output logic               busy_o,
  output logic [LAYER_W-1:0] layer_idx_o,
  output logic [CNT_W-1:0]   out_count_o,
  output logic               layer_done_o,
  output logic               all_done_o
);

  state_e             state;
  logic [CNT_W-1:0]   expected;
  logic [CNT_W-1:0]   cnt_inc;
  logic [LAYER_W-1:0] rd_addr;
  logic [DESC_W-1:0]  rd_data;
  logic               ram_we;

  assign ram_we  = cfg_wr_en_i && (state == ST_IDLE);
  assign cnt_inc = out_count_o + CNT_W'(1);

  // The RAM read is registered, so the address leads the LOAD state by one cycle.
  always_comb begin
    rd_addr = layer_idx_o;
    if (state == ST_IDLE)
      rd_addr = '0;
    else if (state == ST_NEXT)
      rd_addr = layer_idx_o + LAYER_W'(1);
  end

  squ_desc_ram #(
    .DEPTH  (NUM_LAYERS),
    .ADDR_W (LAYER_W),
    .DATA_W (DESC_W)
  ) u_desc_ram (
    .clk     (clk_i),
    .wr_en   (ram_we),
    .wr_addr (cfg_wr_addr_i),
    .wr_data (cfg_wr_data_i),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state                 <= ST_IDLE;
      expected              <= '0;
      start_o               <= 1'b0;
      fifo_squ_bash_clr_o   <= 1'b0;
      exp_1x1_en_o          <= 1'b0;
      avg_en_o              <= 1'b0;
      tot_squ_addr_limit_o  <= '0;
      no_of_squ_kernals_o   <= '0;
      squ_3x3_ker_depth_o   <= '0;
      squ_layer_dimension_o <= '0;
      busy_o                <= 1'b0;
      layer_idx_o           <= '0;
      out_count_o           <= '0;
      layer_done_o          <= 1'b0;
      all_done_o            <= 1'b0;
    end else begin
      start_o             <= 1'b0;
      fifo_squ_bash_clr_o <= 1'b0;
      layer_done_o        <= 1'b0;
      all_done_o          <= 1'b0;
      if (abort_i) begin
        state       <= ST_IDLE;
        busy_o      <= 1'b0;
        layer_idx_o <= '0;
        out_count_o <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (run_i) begin
              state       <= ST_LOAD;
              busy_o      <= 1'b1;
              layer_idx_o <= '0;
            end
          end
          ST_LOAD: begin
            tot_squ_addr_limit_o  <= rd_data[LIM_LSB +: LIM_W];
            no_of_squ_kernals_o   <= rd_data[KER_LSB +: KER_W];
            squ_3x3_ker_depth_o   <= rd_data[DEP_LSB +: DEP_W];
            squ_layer_dimension_o <= rd_data[DIM_LSB +: DIM_W];
            exp_1x1_en_o          <= rd_data[EXP_BIT];
            avg_en_o              <= rd_data[AVG_BIT];
            expected              <= calc_expected(rd_data[AVG_BIT],
                                                   rd_data[DIM_LSB +: DIM_W],
                                                   rd_data[KER_LSB +: KER_W]);
            out_count_o           <= '0;
            fifo_squ_bash_clr_o   <= 1'b1;
            state                 <= ST_CLR;
          end
          ST_CLR: begin
            start_o <= 1'b1;
            state   <= ST_START;
          end
          ST_START: begin
            state <= ST_RUN;
          end
          ST_RUN: begin
            if (out_beat_i) begin
              out_count_o <= cnt_inc;
              if (cnt_inc == expected) begin
                layer_done_o <= 1'b1;
                if (layer_idx_o == last_layer_i) begin
                  state      <= ST_IDLE;
                  busy_o     <= 1'b0;
                  all_done_o <= 1'b1;
                end else begin
                  state <= ST_NEXT;
                end
              end
            end
          end
          ST_NEXT: begin
            layer_idx_o <= layer_idx_o + LAYER_W'(1);
            state       <= ST_LOAD;
          end
          default: begin
            state  <= ST_IDLE;
            busy_o <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

`default_nettype wire
